// File: rtl/nw_display_pkg.sv
// nw_display_pkg
// Shared definitions for the Needleman-Wunsch progress display path.
//   - 7-bit segment codes (active-low cathodes, bit order gfedcba).
//   - Controller state encoding used by progress_percent_encoder.
//   - Percentage scaling constants.
// The display multiplexer imports this package as well. The reserved code
// pairs (DASH/DASH for idle, M/A for complete) are therefore defined only here.
package nw_display_pkg;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_M     = 7'b1101010;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_X     = 7'b0001001;
  localparam logic [6:0] SEG_PERC1 = 7'b0011100;
  localparam logic [6:0] SEG_PERC2 = 7'b0100011;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int PCT_SCALE = 100;
  localparam int PCT_SHOW_MAX = 99;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DIV  = 3'd2,
    ST_BCD  = 3'd3,
    ST_FULL = 3'd4
  } state_t;

endpackage

// File: rtl/progress_percent_encoder_if.sv
// progress_percent_encoder_if
// Bundles the handshake between the scoring core / display side and the
// progress encoder.
//   start      : one-cycle pulse, a new alignment run begins
//   cell_done  : one-cycle pulse per computed matrix cell
//   done       : run finished (level or pulse)
//   digit1     : tens segment pattern (active-low, gfedcba)
//   digit2     : ones segment pattern
//   busy       : division in flight
// master drives the core-side inputs; slave is the encoder.
interface progress_percent_encoder_if;
  logic       start;
  logic       cell_done;
  logic       done;
  logic [6:0] digit1;
  logic [6:0] digit2;
  logic       busy;

  modport master (
    output start, cell_done, done,
    input  digit1, digit2, busy
  );

  modport slave (
    input  start, cell_done, done,
    output digit1, digit2, busy
  );
endinterface

// File: rtl/seg_digit_encoder.sv
// seg_digit_encoder
// Combinational BCD digit to 7-segment map.
//   bcd : 4-bit digit value; values above 9 display blank (OFF)
//   seg : active-low segment pattern, gfedcba
module seg_digit_encoder
  import nw_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = SEG_ONE;
      4'd2: seg = SEG_TWO;
      4'd3: seg = SEG_THREE;
      4'd4: seg = SEG_FOUR;
      4'd5: seg = SEG_FIVE;
      4'd6: seg = SEG_SIX;
      4'd7: seg = SEG_SEVEN;
      4'd8: seg = SEG_EIGHT;
      4'd9: seg = SEG_NINE;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/progress_percent_encoder.sv
// progress_percent_encoder
// Turns matrix-fill progress (cell_done pulses out of N*N cells) into two
// 7-segment digits showing the integer percentage. The percentage comes from a
// sequential restoring divider, one quotient bit per cycle.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : progress_percent_encoder_if.slave (start, cell_done, done in;
//          digit1, digit2, busy out)
// Parameter N: sequence length; the matrix holds N*N cells.
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens digit when it
// is zero, both on the start pattern and on computed values.
//
// state | meaning
// IDLE  | after reset, shows DASH/DASH and ignores cell_done/done
// WAIT  | run active; watch for a count change, done or full count
// DIV   | restoring division of snapshot*100 by TOTAL, one bit per cycle
// BCD   | clamp quotient, split into tens/ones, register the digits
// FULL  | run complete; shows M/A until start or rst
module progress_percent_encoder
  import nw_display_pkg::*;
#(
  parameter int N = 5
)
(
  input  logic clk,
  input  logic rst,
  progress_percent_encoder_if.slave bus
);

  localparam int TOTAL = N * N;
  localparam int NW    = $clog2(TOTAL * PCT_SCALE + 1);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BW    = $clog2(NW + 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] START_TENS = SEG_OFF;
`else
  localparam logic [6:0] START_TENS = SEG_ZERO;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] snapshot;
  logic [NW-1:0] num;
  logic [NW:0]   rem;
  logic [6:0]    quo;
  logic [BW-1:0] bits_left;

  logic          counting;
  logic          hit_total;
  logic [NW:0]   rem_shift;
  logic          rem_fits;
  logic [6:0]    pct;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [6:0]    seg_tens;
  logic [6:0]    seg_ones;
  logic [6:0]    tens_shown;

  // Pulses count only while a run is active and not yet complete.
  assign counting = bus.cell_done &&
                    ((state == ST_WAIT) || (state == ST_DIV) || (state == ST_BCD));

  // The pulse that makes count reach TOTAL also selects FULL at that same edge,
  // so M/A appears one edge after the final pulse.
  assign hit_total = (count == CW'(TOTAL)) ||
                     (counting && (count == CW'(TOTAL - 1)));

  always_comb begin
    rem_shift = '0;
    rem_fits  = 1'b0;
    rem_shift = (rem << 1) | {{NW{1'b0}}, num[NW-1]};
    rem_fits  = (rem_shift >= (NW+1)'(TOTAL));
  end

  always_comb begin
    pct  = quo;
    tens = '0;
    ones = '0;
    if (quo >= 7'(PCT_SCALE)) pct = 7'(PCT_SHOW_MAX);
    tens = 4'(pct / 7'd10);
    ones = 4'(pct % 7'd10);
  end

  seg_digit_encoder u_tens (
    .bcd (tens),
    .seg (seg_tens)
  );

  seg_digit_encoder u_ones (
    .bcd (ones),
    .seg (seg_ones)
  );

  always_comb begin
    tens_shown = seg_tens;
`ifdef LEADING_ZERO_BLANK_EN
    if (tens == 4'd0) tens_shown = SEG_OFF;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      snapshot   <= '0;
      num        <= '0;
      rem        <= '0;
      quo        <= '0;
      bits_left  <= '0;
      bus.digit1 <= SEG_DASH;
      bus.digit2 <= SEG_DASH;
      bus.busy   <= 1'b0;
    end else if (bus.start) begin
      state      <= ST_WAIT;
      count      <= '0;
      snapshot   <= '0;
      bus.digit1 <= START_TENS;
      bus.digit2 <= SEG_ZERO;
      bus.busy   <= 1'b0;
    end else begin
      if (counting && (count != CW'(TOTAL))) count <= count + CW'(1);

      case (state)
        ST_IDLE: begin
          bus.busy <= 1'b0;
        end

        ST_WAIT: begin
          if (bus.done || hit_total) begin
            state      <= ST_FULL;
            bus.digit1 <= SEG_M;
            bus.digit2 <= SEG_A;
            bus.busy   <= 1'b0;
          end else if (count != snapshot) begin
            // Pulses seen after this point wait for the next WAIT pass.
            snapshot  <= count;
            num       <= NW'(count) * NW'(PCT_SCALE);
            rem       <= '0;
            quo       <= '0;
            bits_left <= BW'(NW);
            state     <= ST_DIV;
            bus.busy  <= 1'b1;
          end
        end

        ST_DIV: begin
          if (bus.done || hit_total) begin
            state      <= ST_FULL;
            bus.digit1 <= SEG_M;
            bus.digit2 <= SEG_A;
            bus.busy   <= 1'b0;
          end else begin
            num       <= num << 1;
            rem       <= rem_fits ? (rem_shift - (NW+1)'(TOTAL)) : rem_shift;
            // Only the low 7 quotient bits survive; the result is at most 100.
            quo       <= {quo[5:0], rem_fits};
            bits_left <= bits_left - BW'(1);
            if (bits_left == BW'(1)) state <= ST_BCD;
          end
        end

        ST_BCD: begin
          if (bus.done || hit_total) begin
            state      <= ST_FULL;
            bus.digit1 <= SEG_M;
            bus.digit2 <= SEG_A;
            bus.busy   <= 1'b0;
          end else begin
            bus.digit1 <= tens_shown;
            bus.digit2 <= seg_ones;
            bus.busy   <= 1'b0;
            state      <= ST_WAIT;
          end
        end

        ST_FULL: begin
          bus.digit1 <= SEG_M;
          bus.digit2 <= SEG_A;
          bus.busy   <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          bus.digit1 <= SEG_DASH;
          bus.digit2 <= SEG_DASH;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_progress_percent_encoder.sv
// tb_progress_percent_encoder
// Directed bench for progress_percent_encoder with N=5 (TOTAL=25, 14-edge
// recompute latency). Honours LEADING_ZERO_BLANK_EN for expected tens digits.
module tb_progress_percent_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  progress_percent_encoder_if bus();

  progress_percent_encoder #(.N(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] P_OFF  = 7'b1111111;
  localparam logic [6:0] P_DASH = 7'b0111111;
  localparam logic [6:0] P_ZERO = 7'b1000000;
  localparam logic [6:0] P_M    = 7'b1101010;
  localparam logic [6:0] P_A    = 7'b0001000;

  logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_tens(input int pct);
    if (BLANK && (pct / 10) == 0) return P_OFF;
    return seg_tbl[pct / 10];
  endfunction

  function automatic int decode(input logic [6:0] d1, input logic [6:0] d2);
    int t;
    int o;
    t = -1;
    o = -1;
    for (int i = 0; i < 10; i++) begin
      if (d1 == seg_tbl[i]) t = i;
      if (d2 == seg_tbl[i]) o = i;
    end
    if (BLANK && d1 == P_OFF) t = 0;
    if (t < 0 || o < 0) return -1;
    return t * 10 + o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cell();
    bus.cell_done = 1'b1;
    tick();
    bus.cell_done = 1'b0;
  endtask

  task automatic do_start(input string name);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.digit1 !== exp_tens(0) || bus.digit2 !== P_ZERO || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s start: digits %b/%b busy %b, expected %b/%b busy 0",
               name, bus.digit1, bus.digit2, bus.busy, exp_tens(0), P_ZERO);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cell_done = 1'b0;
    bus.done = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.digit1 !== P_DASH || bus.digit2 !== P_DASH || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, P_DASH, P_DASH);
    end
    rst = 1'b0;
    tick();
    pulse_cell();
    pulse_cell();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (20) tick();
    checks++;
    if (bus.digit1 !== P_DASH || bus.digit2 !== P_DASH || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, P_DASH, P_DASH);
    end
  endtask

  task automatic test_one_cell();
    do_start("one_cell");
    pulse_cell();
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy %b, expected 1", bus.busy);
    end
    repeat (12) tick();
    checks++;
    if (bus.digit1 !== exp_tens(0) || bus.digit2 !== P_ZERO || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: digits %b/%b busy %b at edge 13, expected %b/%b busy 1",
               bus.digit1, bus.digit2, bus.busy, exp_tens(0), P_ZERO);
    end
    tick();
    checks++;
    if (bus.digit1 !== exp_tens(4) || bus.digit2 !== 7'b0011001 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL one_cell_4pct: digits %b/%b busy %b, expected %b/0011001 busy 0",
               bus.digit1, bus.digit2, bus.busy, exp_tens(4));
    end
  endtask

  task automatic test_spaced(input int pulses);
    int pct;
    do_start("spaced");
    for (int k = 1; k <= pulses; k++) begin
      pulse_cell();
      repeat (19) tick();
      pct = (k * 100) / 25;
      checks++;
      if (bus.digit1 !== exp_tens(pct) || bus.digit2 !== seg_tbl[pct % 10]) begin
        errors++;
        $display("FAIL spaced_%0d_of_%0d: digits %b/%b, expected %b/%b (%0d pct)",
                 k, pulses, bus.digit1, bus.digit2, exp_tens(pct), seg_tbl[pct % 10], pct);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    int val;
    prev = 0;
    do_start("b2b");
    bus.cell_done = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i < 25) begin
        val = decode(bus.digit1, bus.digit2);
        checks++;
        if (val < prev) begin
          errors++;
          $display("FAIL b2b_monotonic cycle %0d: digits %b/%b decode %0d, previous %0d",
                   i, bus.digit1, bus.digit2, val, prev);
        end
        if (val >= 0) prev = val;
      end
    end
    bus.cell_done = 1'b0;
    tick();
    checks++;
    if (bus.digit1 !== P_M || bus.digit2 !== P_A || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, P_M, P_A);
    end
    pulse_cell();
    repeat (16) tick();
    checks++;
    if (bus.digit1 !== P_M || bus.digit2 !== P_A) begin
      errors++;
      $display("FAIL full_hold: digits %b/%b, expected %b/%b",
               bus.digit1, bus.digit2, P_M, P_A);
    end
  endtask

  task automatic test_done();
    do_start("done_div");
    pulse_cell();
    repeat (3) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.digit1 !== P_M || bus.digit2 !== P_A || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_in_div: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, P_M, P_A);
    end
    do_start("done_wait");
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.digit1 !== P_M || bus.digit2 !== P_A) begin
      errors++;
      $display("FAIL done_in_wait: digits %b/%b, expected %b/%b",
               bus.digit1, bus.digit2, P_M, P_A);
    end
  endtask

  task automatic test_reset_mid_div();
    do_start("rst_mid");
    pulse_cell();
    pulse_cell();
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: busy %b, expected 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.digit1 !== P_DASH || bus.digit2 !== P_DASH || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, P_DASH, P_DASH);
    end
    #2 rst = 1'b0;
    tick();
    bus.cell_done = 1'b1;
    do_start("start_beats_cell");
    bus.cell_done = 1'b0;
    repeat (20) tick();
    checks++;
    if (bus.digit1 !== exp_tens(0) || bus.digit2 !== P_ZERO || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL count_cleared: digits %b/%b busy %b, expected %b/%b busy 0",
               bus.digit1, bus.digit2, bus.busy, exp_tens(0), P_ZERO);
    end
    pulse_cell();
    repeat (19) tick();
    checks++;
    if (bus.digit1 !== exp_tens(4) || bus.digit2 !== 7'b0011001) begin
      errors++;
      $display("FAIL after_reset_4pct: digits %b/%b, expected %b/0011001",
               bus.digit1, bus.digit2, exp_tens(4));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one_cell();
    test_spaced(7);
    test_spaced(24);
    test_back_to_back();
    test_done();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
